port_tx_fifo: RTL and testbench

Byte FIFO that feeds the DI input of a read-streaming IOPort8, so an on-chip producer (sampler, packetiser) can stream bytes to the MCU over the SPI gate. The producer pushes bytes with a valid/ready handshake. The IOPort8 consumes them through its STRB/STRT/DONE strobes. The block replaces the free-running counter pattern on streaming ports with real buffered data, and it reports underrun and fill level for diagnostics.

---
 rtl/port_tx_fifo.sv | 100 ++++++++++
 tb/tb_port_tx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/port_tx_fifo.sv
// Byte FIFO feeding the DI input of a read-streaming IOPort8.
// Producer pushes over valid/ready; the IOPort8 pops with STRB. Reports fill level and underrun.
module port_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  EMPTY_BYTE = 8'h00
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [7:0]            WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [7:0]            DI,
    input  logic                  STRB,
    input  logic                  STRT,
    input  logic                  DONE,
    input  logic                  FLUSH,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  UNDERRUN,
    output logic                  BUSY
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    underrun_q, underrun_d;
    logic                    busy_q, busy_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    // Readiness depends only on stored state, so a same-cycle pop never frees a slot early.
    assign push  = WVALID & ~full;
    assign pop   = STRB & ~empty;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        underrun_d = underrun_q;
        busy_d     = busy_q;

        if (FLUSH) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // An underrunning strobe in the same cycle as STRT wins over the clear.
        if (STRT)          underrun_d = 1'b0;
        if (STRB && empty) underrun_d = 1'b1;

        if (DONE) busy_d = 1'b0;
        if (STRT) busy_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (nRST && push && !FLUSH) begin
            mem[wr_ptr_q] <= WDATA;
        end
    end

    assign WREADY   = ~full;
    assign LEVEL    = count_q;
    assign UNDERRUN = underrun_q;
    assign BUSY     = busy_q;
    assign DI       = empty ? EMPTY_BYTE : mem[rd_ptr_q];

endmodule

// File: tb/tb_port_tx_fifo.sv
// Directed self-checking bench for port_tx_fifo.
module tb_port_tx_fifo;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [7:0] di;
    logic       strb;
    logic       strt;
    logic       done;
    logic       flush;
    logic [4:0] level;
    logic       underrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    port_tx_fifo #(
        .DEPTH_LOG2(4),
        .EMPTY_BYTE(8'h00)
    ) dut (
        .CLK      (clk),
        .nRST     (nrst),
        .WDATA    (wdata),
        .WVALID   (wvalid),
        .WREADY   (wready),
        .DI       (di),
        .STRB     (strb),
        .STRT     (strt),
        .DONE     (done),
        .FLUSH    (flush),
        .LEVEL    (level),
        .UNDERRUN (underrun),
        .BUSY     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " level"},    32'(level),    32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " underrun"}, 32'(underrun), 32'd0);
        check({tag, " wready"},   32'(wready),   32'd1);
        check({tag, " di"},       32'(di),       32'h00);
    endtask

    initial begin
        nrst = 1'b0; wdata = '0; wvalid = 1'b0; strb = 1'b0;
        strt = 1'b0; done = 1'b0; flush = 1'b0;
        tick();
        nrst = 1'b1;
        check_reset_state("reset");

        // Three pushes, no pops.
        wvalid = 1'b1;
        wdata = 8'h11; tick();
        wdata = 8'h22; tick();
        wdata = 8'h33; tick();
        wvalid = 1'b0;
        check("fill3 level",    32'(level),    32'd3);
        check("fill3 di",       32'(di),       32'h11);
        check("fill3 wready",   32'(wready),   32'd1);
        check("fill3 underrun", 32'(underrun), 32'd0);

        // Stream them out in one transaction.
        strt = 1'b1; tick(); strt = 1'b0;
        check("strt busy", 32'(busy), 32'd1);
        check("strt di",   32'(di),   32'h11);
        strb = 1'b1;
        tick(); check("pop1 di", 32'(di), 32'h22); check("pop1 level", 32'(level), 32'd2);
        tick(); check("pop2 di", 32'(di), 32'h33); check("pop2 level", 32'(level), 32'd1);
        tick(); check("pop3 di", 32'(di), 32'h00); check("pop3 level", 32'(level), 32'd0);
        strb = 1'b0;
        check("pop3 busy", 32'(busy), 32'd1);
        done = 1'b1; tick(); done = 1'b0;
        check("done busy",     32'(busy),     32'd0);
        check("done underrun", 32'(underrun), 32'd0);

        // Fill to full from a non-zero pointer so the second fill wraps.
        wvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(i);
            tick();
        end
        check("full wready", 32'(wready), 32'd0);
        check("full level",  32'(level),  32'd16);
        wdata = 8'hFF; tick();
        wvalid = 1'b0;
        check("refused level", 32'(level), 32'd16);
        strb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain di %0d", i), 32'(di), 32'(i));
            tick();
        end
        strb = 1'b0;
        check("drained level", 32'(level), 32'd0);
        check("drained di",    32'(di),    32'h00);

        // Underrun on an empty FIFO.
        strt = 1'b1; tick(); strt = 1'b0;
        strb = 1'b1;
        tick();
        check("ur1 underrun", 32'(underrun), 32'd1);
        check("ur1 di",       32'(di),       32'h00);
        tick();
        strb = 1'b0;
        check("ur2 underrun", 32'(underrun), 32'd1);
        check("ur2 level",    32'(level),    32'd0);
        strt = 1'b1; tick(); strt = 1'b0;
        check("ur clear", 32'(underrun), 32'd0);
        done = 1'b1; tick(); done = 1'b0;

        // Half full, then sustained simultaneous push/pop.
        wvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdata = 8'(i);
            tick();
        end
        check("half level", 32'(level), 32'd8);
        strb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wdata = 8'(8 + k);
            check($sformatf("stream di %0d", k), 32'(di), 32'(k));
            tick();
            check($sformatf("stream level %0d", k), 32'(level), 32'd8);
        end
        strb = 1'b0; wvalid = 1'b0;
        check("stream tail di", 32'(di), 32'd20);

        // Flush together with a push.
        flush = 1'b1; wvalid = 1'b1; wdata = 8'hAA;
        #1;
        check("flush wready", 32'(wready), 32'd1);
        tick();
        flush = 1'b0; wvalid = 1'b0;
        check("flush level",    32'(level),    32'd0);
        check("flush di",       32'(di),       32'h00);
        check("flush underrun", 32'(underrun), 32'd0);

        // Reset in the middle of a transaction.
        wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'(8'h50 + i);
            tick();
        end
        wvalid = 1'b0;
        strt = 1'b1; tick(); strt = 1'b0;
        check("mid level", 32'(level), 32'd5);
        check("mid busy",  32'(busy),  32'd1);
        nrst = 1'b0; tick(); nrst = 1'b1;
        check_reset_state("midreset");
        wvalid = 1'b1; wdata = 8'hA5; tick(); wvalid = 1'b0;
        check("post reset di",    32'(di),    32'hA5);
        check("post reset level", 32'(level), 32'd1);
        done = 1'b1; tick(); done = 1'b0;
        check("late done busy", 32'(busy), 32'd0);
        check("late done di",   32'(di),   32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
